// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - MIPS 5-stage hazard, branch-squash and dmem-freeze controller.
// Define PIPE_CTL_PERF_EN to add saturating stall_cnt/flush_cnt performance counters.
module pipe_ctl #(
    parameter int DMEM_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ID_ir,
    input  logic [2:0]       EX_ctlm,
    input  logic [4:0]       EX_rt,
    input  logic [2:0]       MEM_ctlm,
    input  logic             MEM_PCSrc,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             dmem_err,
`ifdef PIPE_CTL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state
);

    localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic                r_err, w_err_nxt;
    logic                w_mem_access;
    logic                w_rt_is_src;
    logic                w_load_use;
    logic                w_flow;
    logic [5:0]          w_opcode;

    assign w_opcode     = ID_ir[31:26];
    assign w_mem_access = MEM_ctlm[1] | MEM_ctlm[0];

    // rt is only a source for R-type, beq, bne and sw; otherwise it is a destination.
    assign w_rt_is_src = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                         (w_opcode == 6'h05) || (w_opcode == 6'h2B);

    assign w_load_use = EX_ctlm[1] && (EX_rt != 5'd0) &&
                        ((EX_rt == ID_ir[25:21]) ||
                         (w_rt_is_src && (EX_rt == ID_ir[20:16])));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_err_nxt   = r_err;
        w_flow      = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;

        case (r_state)
            RUN: begin
                if (w_mem_access && !dmem_ready) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_hold   = 1'b1;
                    w_wcnt_nxt  = WCNT_W'(1);
                    w_state_nxt = DWAIT;
                end else begin
                    w_flow = 1'b1;
                end
            end
            DWAIT: begin
                if (!dmem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    if (r_wcnt == WCNT_W'(DMEM_TIMEOUT)) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    end
                end else begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = RUN;
                    w_flow      = 1'b1;
                end
            end
            ERR: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_wcnt_nxt  = '0;
            end
        endcase

        // Normal flow: a taken branch squashes the wrong path, which also covers any load-use.
        if (w_flow) begin
            if (MEM_PCSrc) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            exmem_flush = 1'b0;
            pipe_hold   = 1'b0;
        end
    end

    assign dmem_err = r_err;
    assign state    = r_state;

`ifdef PIPE_CTL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (ifid_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// tb/tb_pipe_ctl.sv - directed bench for pipe_ctl with a behavioural model checked every cycle.
module tb_pipe_ctl;

    localparam int TMO   = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ID_ir = '0;
    logic [2:0]  EX_ctlm = '0;
    logic [4:0]  EX_rt = '0;
    logic [2:0]  MEM_ctlm = '0;
    logic        MEM_PCSrc = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, dmem_err;
    logic [1:0]  state;
`ifdef PIPE_CTL_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctl #(.DMEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ID_ir(ID_ir), .EX_ctlm(EX_ctlm), .EX_rt(EX_rt),
        .MEM_ctlm(MEM_ctlm), .MEM_PCSrc(MEM_PCSrc), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
        .dmem_err(dmem_err),
`ifdef PIPE_CTL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    wire [8:0] w_obs = {state, pc_write, ifid_write, ifid_flush, idex_bubble,
                        exmem_flush, pipe_hold, dmem_err};

    // Sources read by the instruction in ID; a hazard exists if the load target is one of them.
    function automatic bit hazard(input [31:0] ir, input [2:0] exm, input [4:0] ert);
        logic [5:0] op;
        bit reads_rt;
        op = ir[31:26];
        reads_rt = (op inside {6'h00, 6'h04, 6'h05, 6'h2B});
        if (!exm[1] || ert == 5'd0) return 1'b0;
        return (ert == ir[25:21]) || (reads_rt && ert == ir[20:16]);
    endfunction

    bit m_err = 0, m_waiting = 0;
    int m_waited = 0;
    int m_stalls = 0, m_flushes = 0;

    always @(negedge clk) begin
        bit frozen, branch, lu, mem_acc;
        logic [8:0] exp;
        logic [1:0] st;
        mem_acc = MEM_ctlm[1] | MEM_ctlm[0];
        st = m_err ? 2'd3 : (m_waiting ? 2'd1 : 2'd0);
        if (!rst_n) begin
            exp = 9'b00_1100000;
            m_err = 0; m_waiting = 0; m_waited = 0;
        end else begin
            frozen = m_err || (m_waiting ? !dmem_ready : (mem_acc && !dmem_ready));
            branch = !frozen && MEM_PCSrc;
            lu     = !frozen && !branch && hazard(ID_ir, EX_ctlm, EX_rt);
            exp = {st, !(frozen || lu), !(frozen || lu), branch, branch || lu, branch,
                   frozen, m_err};
            if (!m_err) begin
                if (!frozen) begin
                    m_waiting = 0; m_waited = 0;
                end else if (!m_waiting) begin
                    m_waiting = 1; m_waited = 1;
                end else if (m_waited == TMO) begin
                    m_err = 1; m_waiting = 0;
                end else begin
                    m_waited++;
                end
            end
        end
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL model t=%0t got=%b exp=%b (st,pw,iw,iff,ib,ef,ph,de)", $time, w_obs, exp);
        end
`ifdef PIPE_CTL_PERF_EN
        if (!rst_n) begin
            m_stalls = 0; m_flushes = 0;
        end
        n_checks++;
        if (stall_cnt !== CNT_W'(m_stalls) || flush_cnt !== CNT_W'(m_flushes)) begin
            n_errors++;
            $display("FAIL perf t=%0t got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     $time, stall_cnt, flush_cnt, m_stalls, m_flushes);
        end
        if (rst_n) begin
            if (!exp[6]) m_stalls++;
            if (exp[4]) m_flushes++;
        end
`endif
    end

    localparam logic [31:0] ADD  = 32'h00441820; // add  $3,$2,$4
    localparam logic [31:0] ADDZ = 32'h00041820; // add  $3,$0,$4
    localparam logic [31:0] ADDI = 32'h20A20001; // addi $2,$5,1
    localparam logic [31:0] SW   = 32'hACA20000; // sw   $2,0($5)
    localparam logic [31:0] BEQ  = 32'h10220000; // beq  $1,$2,0

    localparam logic [8:0] IDLE   = 9'b00_1100000;
    localparam logic [8:0] STALL  = 9'b00_0001000;
    localparam logic [8:0] FLUSH  = 9'b00_1111100;
    localparam logic [8:0] FRZ_R  = 9'b00_0000010;
    localparam logic [8:0] FRZ_W  = 9'b01_0000010;
    localparam logic [8:0] REL_FL = 9'b01_1111100;
    localparam logic [8:0] REL_ST = 9'b01_0001000;
    localparam logic [8:0] ERRV   = 9'b11_0000011;

    task automatic cyc(input string name, input logic rst, input [31:0] ir, input [2:0] exm,
                       input [4:0] ert, input [2:0] memm, input pcs, input rdy,
                       input [8:0] exp);
        @(posedge clk);
        #1;
        rst_n = rst; ID_ir = ir; EX_ctlm = exm; EX_rt = ert;
        MEM_ctlm = memm; MEM_PCSrc = pcs; dmem_ready = rdy;
        @(negedge clk);
        n_checks++;
        if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (st,pw,iw,iff,ib,ef,ph,de)", name, w_obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc("reset",          0, 0,    3'b000, 0, 3'b000, 0, 1, IDLE);
        cyc("reset_lu_mask",  0, ADD,  3'b010, 2, 3'b010, 1, 0, IDLE);
        cyc("idle",           1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        cyc("lu_rs",          1, ADD,  3'b010, 2, 3'b000, 0, 0, STALL);
        cyc("lu_after",       1, ADD,  3'b000, 0, 3'b000, 0, 0, IDLE);
        cyc("lu_rt_zero",     1, ADDZ, 3'b010, 0, 3'b000, 0, 0, IDLE);
        cyc("lu_addi_rt",     1, ADDI, 3'b010, 2, 3'b000, 0, 0, IDLE);
        cyc("lu_sw_rt",       1, SW,   3'b010, 2, 3'b000, 0, 0, STALL);
        cyc("lu_beq_rt",      1, BEQ,  3'b010, 2, 3'b000, 0, 0, STALL);
        cyc("store_in_ex",    1, ADD,  3'b001, 2, 3'b000, 0, 0, IDLE);
        cyc("branch",         1, 0,    3'b000, 0, 3'b100, 1, 0, FLUSH);
        cyc("branch_over_lu", 1, ADD,  3'b010, 2, 3'b100, 1, 0, FLUSH);
        cyc("zero_wait",      1, 0,    3'b000, 0, 3'b010, 0, 1, IDLE);
        cyc("zero_wait_next", 1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        // three low dmem_ready cycles, then ready with a deferred branch
        cyc("dw_enter",       1, ADD,  3'b010, 2, 3'b010, 0, 0, FRZ_R);
        cyc("dw_wait1",       1, 0,    3'b000, 0, 3'b010, 0, 0, FRZ_W);
        cyc("dw_wait2",       1, 0,    3'b000, 0, 3'b010, 1, 0, FRZ_W);
        cyc("dw_release_br",  1, 0,    3'b000, 0, 3'b010, 1, 1, REL_FL);
        cyc("dw_after",       1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        cyc("dw2_enter",      1, 0,    3'b000, 0, 3'b001, 0, 0, FRZ_R);
        cyc("dw2_release_lu", 1, ADD,  3'b010, 2, 3'b001, 0, 1, REL_ST);
        cyc("dw2_after",      1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        // timeout: RUN entry plus TMO DWAIT cycles, then ERR
        cyc("to_enter",       1, 0,    3'b000, 0, 3'b010, 0, 0, FRZ_R);
        for (int i = 1; i <= TMO; i++)
            cyc("to_wait",    1, 0,    3'b000, 0, 3'b010, 0, 0, FRZ_W);
        cyc("err",            1, 0,    3'b000, 0, 3'b010, 0, 0, ERRV);
        cyc("err_sticky_rdy", 1, ADD,  3'b010, 2, 3'b010, 1, 1, ERRV);
        cyc("err_sticky",     1, 0,    3'b000, 0, 3'b000, 0, 0, ERRV);
        cyc("err_reset",      0, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        cyc("err_cleared",    1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        // reset in the middle of DWAIT abandons the access
        cyc("mid_enter",      1, 0,    3'b000, 0, 3'b010, 0, 0, FRZ_R);
        cyc("mid_wait",       1, 0,    3'b000, 0, 3'b010, 0, 0, FRZ_W);
        cyc("mid_reset",      0, 0,    3'b000, 0, 3'b010, 0, 0, IDLE);
        cyc("mid_after",      1, 0,    3'b000, 0, 3'b000, 0, 0, IDLE);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
